// File: rtl/data_reg_buf.sv
// DEPTH-entry bus-loaded FIFO register; head visible on DR_HEAD/DR_OUT_H/DR_OUT_L the edge after a load into an empty queue.
// Loads to a full queue without a pop are dropped; DR_BUF_OVF_EN adds a sticky DR_OVF flag for that event.
module data_reg_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [WIDTH-1:0]           BUS,
   input  logic                       DR_LOAD,
   input  logic                       DR_POP,
   input  logic                       DR_CLR,
   input  logic                       DR_BUS_H,
   input  logic                       DR_BUS_L,
   output wire  [WIDTH-1:0]           DR_OUT_H,
   output wire  [WIDTH-1:0]           DR_OUT_L,
   output logic [WIDTH-1:0]           DR_HEAD,
   output logic [$clog2(DEPTH+1)-1:0] DR_COUNT,
   output logic                       DR_EMPTY,
   output logic                       DR_FULL,
   output logic                       DR_OVF
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             push_acc;
   logic             pop_acc;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // When full, a simultaneous pop frees the slot the push lands in.
   assign push_acc = DR_LOAD && (!full || DR_POP);
   assign pop_acc  = DR_POP && !empty;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (DR_CLR) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_acc)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_acc && !pop_acc)
            count <= count + CW'(1);
         else if (pop_acc && !push_acc)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push_acc && !DR_CLR)
         mem[wr_ptr] <= BUS;
   end

`ifdef DR_BUF_OVF_EN
   logic ovf;
   logic ovf_evt;

   assign ovf_evt = DR_LOAD && full && !DR_POP;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         ovf <= 1'b0;
      else if (DR_CLR)
         ovf <= 1'b0;
      else if (ovf_evt)
         ovf <= 1'b1;
   end

   assign DR_OVF = ovf;
`else
   assign DR_OVF = 1'b0;
`endif

   assign DR_HEAD  = empty ? '0 : mem[rd_ptr];
   assign DR_COUNT = count;
   assign DR_EMPTY = empty;
   assign DR_FULL  = full;

   assign DR_OUT_H = DR_BUS_H ? DR_HEAD : {WIDTH{1'bz}};
   assign DR_OUT_L = DR_BUS_L ? DR_HEAD : {WIDTH{1'bz}};

endmodule
